// File: rtl/clock_pkg.sv
// Shared constants and helpers for the alarm-clock timekeeping chain.
// Hour width, BCD digit width and reset-value clamping live here.
package clock_pkg;

    localparam int HOURS_PER_DAY = 24;
    localparam int NOON          = 12;
    localparam int HR_W          = 5;
    localparam int BCD_W         = 4;

    typedef logic [HR_W-1:0]  hour_t;
    typedef logic [BCD_W-1:0] bcd_t;

    localparam hour_t LAST_HOUR = hour_t'(HOURS_PER_DAY - 1);
    localparam hour_t NOON_HOUR = hour_t'(NOON);

    // Out-of-range reset hours fall back to midnight.
    function automatic hour_t clamp_hour(input int h);
        if (h < 0 || h >= HOURS_PER_DAY) begin
            return '0;
        end
        return hour_t'(h);
    endfunction

endpackage

// File: rtl/hr_bcd.sv
// Binary hour (0-23) to displayed BCD digits and PM flag.
// Purely combinational; callers register the outputs.
module hr_bcd
    import clock_pkg::*;
(
    input  logic [HR_W-1:0]  hour,
    input  logic             mode12,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones,
    output logic             pm
);

    hour_t disp;

    // Fold to 12-hour form when requested, then split into two digits.
    always_comb begin
        disp = hour;
        pm   = (hour >= NOON_HOUR);
        if (mode12) begin
            if (hour == '0) begin
                disp = NOON_HOUR;
            end else if (hour > NOON_HOUR) begin
                disp = hour - NOON_HOUR;
            end
        end
        if (disp >= hour_t'(20)) begin
            tens = bcd_t'(2);
            ones = bcd_t'(disp - hour_t'(20));
        end else if (disp >= hour_t'(10)) begin
            tens = bcd_t'(1);
            ones = bcd_t'(disp - hour_t'(10));
        end else begin
            tens = '0;
            ones = bcd_t'(disp);
        end
    end

endmodule

// File: rtl/hr_counter.sv
// Hour-of-day counter: minute-carry advance, manual set, registered
// BCD display digits and a one-cycle day-rollover pulse.
module hr_counter
    import clock_pkg::*;
#(
    parameter int RESET_HOUR = 0
) (
    input  logic             hr_clk,
    input  logic             hr_rst,
    input  logic             hr_en,
    input  logic             hr_carry,
    input  logic             hr_set_mode,
    input  logic             hr_set_inc,
    input  logic             hr_set_dec,
    input  logic             hr_mode12,
    output logic [HR_W-1:0]  hr_count,
    output logic [BCD_W-1:0] hr_tens,
    output logic [BCD_W-1:0] hr_ones,
    output logic             hr_pm,
    output logic             hr_day_out
);

    localparam hour_t RST_H = clamp_hour(RESET_HOUR);

    logic  run_adv;
    logic  set_up;
    logic  set_dn;
    logic  day_wrap;
    hour_t count_d;
    bcd_t  tens_d;
    bcd_t  ones_d;
    logic  pm_d;

    // Next hour: carry advance in run mode, inc/dec in set mode.
    always_comb begin
        run_adv  = !hr_set_mode && hr_en && hr_carry;
        set_up   = hr_set_mode && hr_set_inc && !hr_set_dec;
        set_dn   = hr_set_mode && hr_set_dec && !hr_set_inc;
        day_wrap = run_adv && (hr_count >= LAST_HOUR);
        count_d  = hr_count;
        if (run_adv || set_up) begin
            if (hr_count >= LAST_HOUR) begin
                count_d = '0;
            end else begin
                count_d = hr_count + hour_t'(1);
            end
        end else if (set_dn) begin
            if (hr_count == '0 || hr_count > LAST_HOUR) begin
                count_d = LAST_HOUR;
            end else begin
                count_d = hr_count - hour_t'(1);
            end
        end
    end

    // Count register and day pulse share one edge.
    always_ff @(posedge hr_clk or posedge hr_rst) begin
        if (hr_rst) begin
            hr_count   <= RST_H;
            hr_day_out <= 1'b0;
        end else begin
            hr_count   <= count_d;
            hr_day_out <= day_wrap;
        end
    end

    hr_bcd u_bcd (
        .hour   (hr_count),
        .mode12 (hr_mode12),
        .tens   (tens_d),
        .ones   (ones_d),
        .pm     (pm_d)
    );

    // Display digits trail the count by one edge.
    always_ff @(posedge hr_clk or posedge hr_rst) begin
        if (hr_rst) begin
            hr_tens <= '0;
            hr_ones <= '0;
            hr_pm   <= 1'b0;
        end else begin
            hr_tens <= tens_d;
            hr_ones <= ones_d;
            hr_pm   <= pm_d;
        end
    end

endmodule

// File: tb/tb_hr_counter.sv
// Self-checking bench for hr_counter: per-cycle model comparison
// plus directed literal checks, then randomized traffic.
module tb_hr_counter;

    localparam int RST_HOUR = 0;

    logic       hr_clk = 1'b0;
    logic       hr_rst = 1'b0;
    logic       hr_en = 1'b0;
    logic       hr_carry = 1'b0;
    logic       hr_set_mode = 1'b0;
    logic       hr_set_inc = 1'b0;
    logic       hr_set_dec = 1'b0;
    logic       hr_mode12 = 1'b0;
    logic [4:0] hr_count;
    logic [3:0] hr_tens;
    logic [3:0] hr_ones;
    logic       hr_pm;
    logic       hr_day_out;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    int m_hour = RST_HOUR;
    int m_src_h = 0;
    bit m_src_m = 1'b0;
    bit m_disp_rst = 1'b1;
    bit m_day = 1'b0;

    hr_counter #(.RESET_HOUR(RST_HOUR)) dut (
        .hr_clk      (hr_clk),
        .hr_rst      (hr_rst),
        .hr_en       (hr_en),
        .hr_carry    (hr_carry),
        .hr_set_mode (hr_set_mode),
        .hr_set_inc  (hr_set_inc),
        .hr_set_dec  (hr_set_dec),
        .hr_mode12   (hr_mode12),
        .hr_count    (hr_count),
        .hr_tens     (hr_tens),
        .hr_ones     (hr_ones),
        .hr_pm       (hr_pm),
        .hr_day_out  (hr_day_out)
    );

    always #5 hr_clk = ~hr_clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int next_hour(input int h, input bit en,
                                     input bit cy, input bit sm,
                                     input bit inc, input bit dec);
        if (!sm) begin
            return (en && cy) ? (h + 1) % 24 : h;
        end
        if (inc && !dec) return (h + 1) % 24;
        if (dec && !inc) return (h + 23) % 24;
        return h;
    endfunction

    function automatic int disp_of(input int h, input bit m12);
        if (!m12) return h;
        return (h % 12 == 0) ? 12 : h % 12;
    endfunction

    // Reference model: hour of day plus what the display should show.
    always @(posedge hr_clk or posedge hr_rst) begin
        if (hr_rst) begin
            m_hour     <= RST_HOUR;
            m_day      <= 1'b0;
            m_disp_rst <= 1'b1;
            m_src_h    <= 0;
            m_src_m    <= 1'b0;
        end else begin
            m_hour     <= next_hour(m_hour, hr_en, hr_carry, hr_set_mode,
                                    hr_set_inc, hr_set_dec);
            m_day      <= !hr_set_mode && hr_en && hr_carry && m_hour == 23;
            m_disp_rst <= 1'b0;
            m_src_h    <= m_hour;
            m_src_m    <= hr_mode12;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge hr_clk) begin
        if (chk_on) begin
            chk("count", int'(hr_count), m_hour);
            chk("day_out", int'(hr_day_out), int'(m_day));
            if (m_disp_rst) begin
                chk("tens", int'(hr_tens), 0);
                chk("ones", int'(hr_ones), 0);
                chk("pm", int'(hr_pm), 0);
            end else begin
                chk("tens", int'(hr_tens), disp_of(m_src_h, m_src_m) / 10);
                chk("ones", int'(hr_ones), disp_of(m_src_h, m_src_m) % 10);
                chk("pm", int'(hr_pm), int'(m_src_h >= 12));
            end
        end
    end

    task automatic tick();
        @(posedge hr_clk);
        @(negedge hr_clk);
        #1;
    endtask

    task automatic drv(input bit en, input bit cy, input bit sm,
                       input bit inc, input bit dec);
        hr_en       = en;
        hr_carry    = cy;
        hr_set_mode = sm;
        hr_set_inc  = inc;
        hr_set_dec  = dec;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #2 hr_rst = 1'b1;
        #1;
        chk("rst_count", int'(hr_count), 0);
        chk("rst_tens", int'(hr_tens), 0);
        chk("rst_ones", int'(hr_ones), 0);
        chk("rst_pm", int'(hr_pm), 0);
        chk("rst_day", int'(hr_day_out), 0);
        chk_on = 1'b1;
        @(negedge hr_clk);
        #1 hr_rst = 1'b0;

        drv(1, 1, 0, 0, 0);
        ticks(3);
        chk("three_carries", int'(hr_count), 3);
        drv(0, 0, 0, 0, 0);
        tick();
        chk("disp3_tens", int'(hr_tens), 0);
        chk("disp3_ones", int'(hr_ones), 3);
        chk("disp3_pm", int'(hr_pm), 0);

        drv(0, 0, 1, 1, 0);
        ticks(20);
        chk("set_to_23", int'(hr_count), 23);
        drv(1, 1, 0, 0, 0);
        tick();
        chk("wrap_count", int'(hr_count), 0);
        chk("wrap_day", int'(hr_day_out), 1);
        drv(0, 0, 0, 0, 0);
        tick();
        chk("day_one_cycle", int'(hr_day_out), 0);
        chk("mid24_tens", int'(hr_tens), 0);
        chk("mid24_ones", int'(hr_ones), 0);
        hr_mode12 = 1'b1;
        ticks(2);
        chk("mid12_tens", int'(hr_tens), 1);
        chk("mid12_ones", int'(hr_ones), 2);
        chk("mid12_pm", int'(hr_pm), 0);

        hr_mode12 = 1'b0;
        drv(0, 0, 1, 1, 0);
        ticks(13);
        drv(0, 0, 0, 0, 0);
        tick();
        chk("h13_24_tens", int'(hr_tens), 1);
        chk("h13_24_ones", int'(hr_ones), 3);
        chk("h13_24_pm", int'(hr_pm), 1);
        hr_mode12 = 1'b1;
        ticks(2);
        chk("h13_12_tens", int'(hr_tens), 0);
        chk("h13_12_ones", int'(hr_ones), 1);
        chk("h13_12_pm", int'(hr_pm), 1);
        drv(0, 0, 1, 0, 1);
        tick();
        drv(0, 0, 0, 0, 0);
        ticks(2);
        chk("h12_12_tens", int'(hr_tens), 1);
        chk("h12_12_ones", int'(hr_ones), 2);
        chk("h12_12_pm", int'(hr_pm), 1);
        hr_mode12 = 1'b0;

        drv(0, 0, 1, 1, 0);
        ticks(12);
        chk("set_wrap_to_0", int'(hr_count), 0);
        drv(0, 0, 1, 0, 1);
        tick();
        chk("set_dec_23", int'(hr_count), 23);
        chk("set_dec_noday", int'(hr_day_out), 0);
        drv(0, 0, 1, 1, 0);
        tick();
        chk("set_inc_0", int'(hr_count), 0);
        chk("set_inc_noday", int'(hr_day_out), 0);
        drv(0, 0, 1, 1, 1);
        tick();
        chk("set_both", int'(hr_count), 0);
        drv(1, 1, 1, 0, 0);
        ticks(5);
        chk("set_carry_frozen", int'(hr_count), 0);

        drv(0, 0, 1, 1, 0);
        ticks(17);
        drv(1, 0, 0, 0, 0);
        ticks(2);
        chk("pre_rst_17", int'(hr_count), 17);
        drv(1, 1, 0, 0, 0);
        hr_rst = 1'b1;
        #1;
        chk("async_count", int'(hr_count), 0);
        chk("async_tens", int'(hr_tens), 0);
        chk("async_ones", int'(hr_ones), 0);
        chk("async_pm", int'(hr_pm), 0);
        ticks(3);
        chk("carry_in_rst", int'(hr_count), 0);
        hr_rst = 1'b0;
        tick();
        chk("first_after_rst", int'(hr_count), 1);

        drv(1, 0, 0, 0, 0);
        ticks(100);
        chk("en_no_carry", int'(hr_count), 1);
        drv(0, 1, 0, 0, 0);
        ticks(20);
        chk("carry_no_en", int'(hr_count), 1);

        for (int i = 0; i < 3000; i++) begin
            drv(1'($urandom_range(0, 1)),
                $urandom_range(0, 9) < 6,
                $urandom_range(0, 9) < 2,
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
            if ($urandom_range(0, 15) == 0) hr_mode12 = ~hr_mode12;
            hr_rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        hr_rst = 1'b0;
        tick();
        chk_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
